// File: rtl/i2c_pkg.sv
// Shared FSM state, command type and default bit-period timing for the
// I2C command sequencer and its FIFO.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    COLLECT
  } state_e;

  localparam int DEF_TICK_DIV = 500;
  localparam int DEF_WR_SLOTS = 24;
  localparam int DEF_RD_SLOTS = 33;
  localparam int DEF_GUARD    = 2;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Host command/response channel plus engine-side signals of the sequencer.
// slave = the sequencer, master = whoever drives host and engine inputs.
interface i2c_cmd_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        i2c_en;
  logic [7:0]  i2c_addr;
  logic [7:0]  i2c_data;
  logic [15:0] i2c_rdata;
  logic        i2c_ack;
  logic        busy;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, rsp_ready, i2c_rdata, i2c_ack,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, i2c_en, i2c_addr, i2c_data, busy
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_data, rsp_ready, i2c_rdata, i2c_ack,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, i2c_en, i2c_addr, i2c_data, busy
  );

endinterface

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO with show-ahead read; DEPTH must be a power of two.
module i2c_cmd_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic i_push,
  input  cmd_t i_din,
  input  logic i_pop,
  output cmd_t o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depthCheck
    $error("i2c_cmd_fifo: DEPTH must be a power of two >= 2");
  end

  cmd_t        r_mem [DEPTH];
  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  logic        w_doPush;
  logic        w_doPop;

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_dout   = r_mem[r_rdPtr[AW-1:0]];

  // Storage needs no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk_sys) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Command front-end for the I2C engine: queues host commands, launches and times one
// transaction each, returns a response. NACK capture is enabled by I2C_SEQ_ACK_CHECK_EN.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int WR_SLOTS   = DEF_WR_SLOTS,
  parameter int RD_SLOTS   = DEF_RD_SLOTS,
  parameter int GUARD      = DEF_GUARD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_sys,
  input  logic               rst,
  i2c_cmd_sequencer_if.slave io_bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (RD_SLOTS + GUARD > 63 || WR_SLOTS + GUARD > 63) begin : g_slotCheck
    $error("i2c_cmd_sequencer: slot count does not fit the 6-bit slot counter");
  end

  cmd_t          w_din;
  cmd_t          w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [5:0]    w_target;
  logic [5:0]    w_slotsNext;

  state_e        r_state;
  logic [TW-1:0] r_timer;
  logic [5:0]    r_slots;
  logic          r_en;
  logic [7:0]    r_addr;
  logic [7:0]    r_data;
  logic          r_rspValid;
  logic [15:0]   r_rspData;

  assign w_din       = {io_bus.cmd_addr, io_bus.cmd_data};
  assign w_push      = io_bus.cmd_valid && io_bus.cmd_ready;
  assign w_pop       = (r_state == IDLE) && !w_empty;
  assign w_target    = r_addr[0] ? 6'(RD_SLOTS + GUARD) : 6'(WR_SLOTS + GUARD);
  assign w_slotsNext = r_slots + 6'd1;

  i2c_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef I2C_SEQ_ACK_CHECK_EN
  logic r_ackFlag;
  logic r_rspErr;
  assign io_bus.rsp_err = r_rspErr;
`else
  logic w_unusedAck;
  assign w_unusedAck    = io_bus.i2c_ack;
  assign io_bus.rsp_err = 1'b0;
`endif

  // COLLECT is entered on the same wrap that brings the slot count to target,
  // so rsp_valid rises 1 + slots*TICK_DIV clocks after the launch pulse.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_slots    <= '0;
      r_en       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
`ifdef I2C_SEQ_ACK_CHECK_EN
      r_ackFlag  <= 1'b0;
      r_rspErr   <= 1'b0;
`endif
    end else begin
      r_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_addr  <= w_head.addr;
            r_data  <= w_head.data;
            r_en    <= 1'b1;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_timer <= '0;
          r_slots <= '0;
`ifdef I2C_SEQ_ACK_CHECK_EN
          r_ackFlag <= 1'b0;
`endif
          r_state <= BUSY;
        end
        BUSY: begin
`ifdef I2C_SEQ_ACK_CHECK_EN
          r_ackFlag <= r_ackFlag | io_bus.i2c_ack;
`endif
          if (r_timer == TW'(TICK_DIV - 1)) begin
            r_timer <= '0;
            r_slots <= w_slotsNext;
            if (w_slotsNext == w_target) begin
              r_rspValid <= 1'b1;
              r_rspData  <= r_addr[0] ? io_bus.i2c_rdata : 16'h0000;
`ifdef I2C_SEQ_ACK_CHECK_EN
              r_rspErr   <= r_ackFlag | io_bus.i2c_ack;
`endif
              r_state    <= COLLECT;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        COLLECT: begin
          if (r_rspValid && io_bus.rsp_ready) begin
            r_rspValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.cmd_ready = !w_full && !rst;
  assign io_bus.rsp_valid = r_rspValid;
  assign io_bus.rsp_data  = r_rspData;
  assign io_bus.i2c_en    = r_en;
  assign io_bus.i2c_addr  = r_addr;
  assign io_bus.i2c_data  = r_data;
  assign io_bus.busy      = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with TICK_DIV shortened to 8 so every
// scenario stays short; expected latencies below are worked out for that divider.
module tb_i2c_cmd_sequencer;

  // Write: 26 slots * 8 + 1, read: 35 slots * 8 + 1.
  localparam int WrLatency = 209;
  localparam int RdLatency = 281;
  // Launch-to-launch with rsp_ready held high: 209 to rsp_valid, 1 to accept, 1 to pop.
  localparam int WrEnGap   = 211;

`ifdef I2C_SEQ_ACK_CHECK_EN
  localparam logic AckErr = 1'b1;
`else
  localparam logic AckErr = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic rst;

  always #5 clk_sys = ~clk_sys;

  i2c_cmd_sequencer_if bus ();

  i2c_cmd_sequencer #(
    .TICK_DIV   (8),
    .WR_SLOTS   (24),
    .RD_SLOTS   (33),
    .GUARD      (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .io_bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  int         cyc          = 0;
  int         enCount      = 0;
  int         lastEnCyc    = 0;
  int         rspRiseCyc   = 0;
  logic       prevRspValid = 1'b0;
  logic [7:0] enAddrLog [$];
  int         enGapLog  [$];

  // Records every launch pulse and rsp_valid rise against a free-running cycle count.
  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (bus.i2c_en) begin
      enGapLog.push_back(cyc - lastEnCyc);
      enAddrLog.push_back(bus.i2c_addr);
      lastEnCyc <= cyc;
      enCount   <= enCount + 1;
    end
    if (bus.rsp_valid && !prevRspValid) rspRiseCyc <= cyc;
    prevRspValid <= bus.rsp_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
    int n = 0;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("cmdAccepted", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk_sys);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input string tag, input int budget);
    int n = 0;
    while (!bus.rsp_valid && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    @(negedge clk_sys);
    checkOutput(tag, 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic acceptRsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk_sys);
    bus.rsp_ready = 1'b0;
    checkOutput("rspDropped", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput(tag, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int enBase;
    int logBase;
    int n;

    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_addr   = 8'h00;
    bus.cmd_data   = 8'h00;
    bus.rsp_ready  = 1'b0;
    bus.i2c_rdata  = 16'hBEEF;
    bus.i2c_ack    = 1'b0;
    repeat (3) @(negedge clk_sys);

    $display("[TB] reset values");
    checkOutput("rstCmdReady", 32'(bus.cmd_ready), 32'd0);
    checkOutput("rstRspValid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rstRspData",  32'(bus.rsp_data),  32'd0);
    checkOutput("rstRspErr",   32'(bus.rsp_err),   32'd0);
    checkOutput("rstEn",       32'(bus.i2c_en),    32'd0);
    checkOutput("rstAddr",     32'(bus.i2c_addr),  32'd0);
    checkOutput("rstData",     32'(bus.i2c_data),  32'd0);
    checkOutput("rstBusy",     32'(bus.busy),      32'd0);
    rst = 1'b0;
    @(negedge clk_sys);
    checkOutput("cmdReadyAfterRst", 32'(bus.cmd_ready), 32'd1);

    $display("[TB] single write");
    enBase = enCount;
    applyStimulus(8'h34, 8'hA5);
    repeat (20) @(negedge clk_sys);
    checkOutput("wrAddrStable", 32'(bus.i2c_addr), 32'h34);
    checkOutput("wrDataStable", 32'(bus.i2c_data), 32'hA5);
    checkOutput("wrBusy",       32'(bus.busy),     32'd1);
    waitRsp("wrRspValid", 400);
    checkOutput("wrLatency", 32'(rspRiseCyc - lastEnCyc), 32'(WrLatency));
    checkOutput("wrRspData", 32'(bus.rsp_data), 32'h0000);
    checkOutput("wrRspErr",  32'(bus.rsp_err),  32'd0);
    checkOutput("wrOneLaunch", 32'(enCount - enBase), 32'd1);
    checkOutput("wrAddrHeld",  32'(bus.i2c_addr), 32'h34);
    acceptRsp();

    $display("[TB] single read");
    enBase = enCount;
    applyStimulus(8'h35, 8'h00);
    waitRsp("rdRspValid", 500);
    checkOutput("rdLatency",   32'(rspRiseCyc - lastEnCyc), 32'(RdLatency));
    checkOutput("rdRspData",   32'(bus.rsp_data), 32'hBEEF);
    checkOutput("rdOneLaunch", 32'(enCount - enBase), 32'd1);
    acceptRsp();

    $display("[TB] fifo full");
    bus.rsp_ready = 1'b1;
    enBase  = enCount;
    logBase = enAddrLog.size();
    applyStimulus(8'h10, 8'h01);
    applyStimulus(8'h12, 8'h02);
    applyStimulus(8'h14, 8'h03);
    applyStimulus(8'h16, 8'h04);
    checkOutput("fifoThreeQueued", 32'(bus.cmd_ready), 32'd1);
    applyStimulus(8'h18, 8'h05);
    checkOutput("fifoFull", 32'(bus.cmd_ready), 32'd0);
    waitIdle("fifoDrained", 3000);
    checkOutput("fifoLaunches", 32'(enCount - enBase), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("fifoOrder%0d", i), 32'(enAddrLog[logBase + i]), 32'(8'h10 + 2 * i));
    end
    for (int i = 1; i < 5; i++) begin
      checkOutput($sformatf("fifoGap%0d", i), 32'(enGapLog[logBase + i]), 32'(WrEnGap));
    end
    bus.rsp_ready = 1'b0;

    $display("[TB] backpressure");
    enBase = enCount;
    bus.i2c_rdata = 16'hC3A5;
    applyStimulus(8'h21, 8'h00);
    applyStimulus(8'h22, 8'h77);
    waitRsp("bpRspValid", 500);
    bus.i2c_rdata = 16'h1234;
    repeat (1000) @(negedge clk_sys);
    checkOutput("bpValidHeld", 32'(bus.rsp_valid), 32'd1);
    checkOutput("bpDataHeld",  32'(bus.rsp_data),  32'hC3A5);
    checkOutput("bpNoLaunch",  32'(enCount - enBase), 32'd1);
    checkOutput("bpAddrHeld",  32'(bus.i2c_addr), 32'h21);
    checkOutput("bpCmdReady",  32'(bus.cmd_ready), 32'd1);
    acceptRsp();
    n = 0;
    while ((enCount - enBase) < 2 && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("bpSecondLaunch", 32'(enCount - enBase), 32'd2);
    checkOutput("bpSecondAddr",   32'(bus.i2c_addr), 32'h22);
    waitRsp("bp2RspValid", 400);
    checkOutput("bp2RspData", 32'(bus.rsp_data), 32'h0000);
    acceptRsp();

    $display("[TB] nack");
    applyStimulus(8'h40, 8'h5A);
    repeat (60) @(negedge clk_sys);
    bus.i2c_ack = 1'b1;
    @(negedge clk_sys);
    bus.i2c_ack = 1'b0;
    waitRsp("nackRspValid", 400);
    checkOutput("nackErr", 32'(bus.rsp_err), 32'(AckErr));
    acceptRsp();
    applyStimulus(8'h42, 8'h00);
    waitRsp("cleanRspValid", 400);
    checkOutput("cleanErr", 32'(bus.rsp_err), 32'd0);
    acceptRsp();

    $display("[TB] reset mid-busy");
    applyStimulus(8'h50, 8'h01);
    applyStimulus(8'h52, 8'h02);
    applyStimulus(8'h54, 8'h03);
    repeat (30) @(negedge clk_sys);
    checkOutput("preRstBusy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midRstCmdReady", 32'(bus.cmd_ready), 32'd0);
    checkOutput("midRstRspValid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midRstRspData",  32'(bus.rsp_data),  32'd0);
    checkOutput("midRstEn",       32'(bus.i2c_en),    32'd0);
    checkOutput("midRstAddr",     32'(bus.i2c_addr),  32'd0);
    checkOutput("midRstData",     32'(bus.i2c_data),  32'd0);
    checkOutput("midRstBusy",     32'(bus.busy),      32'd0);
    @(negedge clk_sys);
    rst = 1'b0;
    enBase = enCount;
    repeat (300) @(negedge clk_sys);
    checkOutput("postRstNoLaunch", 32'(enCount - enBase), 32'd0);
    checkOutput("postRstBusy",     32'(bus.busy),      32'd0);
    checkOutput("postRstCmdReady", 32'(bus.cmd_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
